// File: rtl/seq_datapath.sv
// rtl/seq_datapath.sv - single-bus datapath (regfile, Y, Z, HI/LO, ALU) with internal step sequencer
module seq_datapath #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4,
  parameter int OP_W     = 5
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rc,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result
);

  localparam int SHW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LDY, S_EXE, S_WB, S_WBH} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] y_q, zhi_q, zlo_q;
  logic [OP_W-1:0]   opcode_q;
  logic [REG_AW-1:0] ra_q, rb_q, rc_q;
  logic              use_imm_q;
  logic [DATA_W-1:0] imm_q;

  logic                accept, op_bad, is_mul;
  logic [DATA_W-1:0]   rb_val, rc_val, b_val;
  logic [2*DATA_W-1:0] alu_out;

  function automatic logic in_range(input logic [REG_AW-1:0] idx);
    return (32'(idx) < NUM_REGS);
  endfunction

  assign op_ready = (state_q == S_IDLE);
  assign accept   = op_valid && op_ready;

  assign rd_data = in_range(rd_addr) ? regs[rd_addr] : '0;
  assign rb_val  = in_range(rb_q) ? regs[rb_q] : '0;
  assign rc_val  = in_range(rc_q) ? regs[rc_q] : '0;
  assign b_val   = use_imm_q ? imm_q : rc_val;

  assign op_bad = (opcode_q > OP_W'(8)) || !in_range(ra_q) || !in_range(rb_q) || !in_range(rc_q);
  assign is_mul = (opcode_q == OP_W'(8));

  always_comb begin
    alu_out = '0;
    case (opcode_q)
      OP_W'(0): alu_out[DATA_W-1:0] = y_q + b_val;
      OP_W'(1): alu_out[DATA_W-1:0] = y_q - b_val;
      OP_W'(2): alu_out[DATA_W-1:0] = y_q & b_val;
      OP_W'(3): alu_out[DATA_W-1:0] = y_q | b_val;
      OP_W'(4): alu_out[DATA_W-1:0] = y_q << b_val[SHW-1:0];
      OP_W'(5): alu_out[DATA_W-1:0] = y_q >> b_val[SHW-1:0];
      OP_W'(6): alu_out[DATA_W-1:0] = ~y_q;
      OP_W'(7): alu_out[DATA_W-1:0] = '0 - y_q;
      OP_W'(8): alu_out = {{DATA_W{1'b0}}, y_q} * {{DATA_W{1'b0}}, b_val};
      default:  alu_out = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (op_valid) state_d = S_LDY;
      S_LDY:   state_d = S_EXE;
      S_EXE:   state_d = S_WB;
      // an erroring MUL skips the HI step, just like any other erroring op
      S_WB:    state_d = (is_mul && !op_bad) ? S_WBH : S_IDLE;
      S_WBH:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      y_q       <= '0;
      zhi_q     <= '0;
      zlo_q     <= '0;
      hi        <= '0;
      lo        <= '0;
      result    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      opcode_q  <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      err     <= 1'b0;
      if (accept) begin
        opcode_q  <= opcode;
        ra_q      <= ra;
        rb_q      <= rb;
        rc_q      <= rc;
        use_imm_q <= use_imm;
        imm_q     <= imm;
      end
      // preload lands before LDY samples, so an op accepted on the same edge sees it
      if (state_q == S_IDLE && ld_en && in_range(ld_addr)) regs[ld_addr] <= ld_data;
      case (state_q)
        S_LDY: y_q <= rb_val;
        S_EXE: {zhi_q, zlo_q} <= alu_out;
        S_WB: begin
          if (!op_bad) begin
            if (is_mul) lo <= zlo_q;
            else        regs[ra_q] <= zlo_q;
            result <= zlo_q;
          end
          if (!(is_mul && !op_bad)) begin
            done <= 1'b1;
            err  <= op_bad;
          end
        end
        S_WBH: begin
          hi   <= zhi_q;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_datapath.sv
// tb/tb_seq_datapath.sv - directed self-checking bench for seq_datapath
module tb_seq_datapath;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [4:0]  opcode = '0;
  logic [3:0]  ra = '0, rb = '0, rc = '0;
  logic        use_imm = 1'b0;
  logic [31:0] imm = '0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data, hi, lo, result;
  logic        done, err;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  seq_datapath dut (
    .clock(clock), .clear(clear), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .ra(ra), .rb(rb), .rc(rc), .use_imm(use_imm), .imm(imm),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .hi(hi), .lo(lo),
    .done(done), .err(err), .result(result)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    rd_addr = a;
    #1 v = rd_data;
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    @(negedge clock);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clock);
    #1 ld_en = 1'b0;
  endtask

  // issue one op from IDLE; lat = edges from accept to done, -1 on timeout
  task automatic run_op(input logic [4:0] opc, input logic [3:0] a, b, c,
                        input logic ui, input logic [31:0] im, output int lat);
    int acc;
    lat = -1;
    @(negedge clock);
    opcode = opc; ra = a; rb = b; rc = c; use_imm = ui; imm = im; op_valid = 1'b1;
    @(posedge clock);
    #1 acc = cyc;
    op_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done) begin
        lat = cyc - acc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    clear = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passes++;
    checks++; if (result !== 32'h0) $display("FAIL reset_result got %h exp 0", result); else passes++;
    checks++; if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo got %h exp 0", {hi, lo}); else passes++;
    clear = 1'b1;
    @(negedge clock);
    checks++; if (op_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", op_ready); else passes++;
    rd(4'd0, v);
    checks++; if (v !== 32'h0) $display("FAIL reset_r0 got %h exp 0", v); else passes++;
  endtask

  task automatic test_add;
    int lat;
    logic [31:0] v;
    preload(4'd2, 32'd7);
    preload(4'd3, 32'd5);
    run_op(5'd0, 4'd1, 4'd2, 4'd3, 1'b0, 32'h0, lat);
    checks++; if (lat !== 3) $display("FAIL add_latency got %0d exp 3", lat); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL add_err got %b exp 0", err); else passes++;
    checks++; if (result !== 32'd12) $display("FAIL add_result got %h exp c", result); else passes++;
    checks++; if (op_ready !== 1'b1) $display("FAIL add_ready_at_done got %b exp 1", op_ready); else passes++;
    rd(4'd1, v);
    checks++; if (v !== 32'd12) $display("FAIL add_r1 got %h exp c", v); else passes++;
    @(negedge clock);
    checks++; if (done !== 1'b0) $display("FAIL add_done_pulse got %b exp 0", done); else passes++;
  endtask

  task automatic test_sub_neg;
    int lat;
    logic [31:0] v;
    preload(4'd2, 32'd3);
    run_op(5'd1, 4'd4, 4'd2, 4'd0, 1'b1, 32'd5, lat);
    rd(4'd4, v);
    checks++; if (v !== 32'hFFFF_FFFE) $display("FAIL sub_imm_r4 got %h exp fffffffe", v); else passes++;
    run_op(5'd7, 4'd8, 4'd2, 4'd0, 1'b0, 32'h0, lat);
    rd(4'd8, v);
    checks++; if (v !== 32'hFFFF_FFFD) $display("FAIL neg_r8 got %h exp fffffffd", v); else passes++;
  endtask

  task automatic test_logic_shift;
    // R2 = 3 from test_sub_neg
    logic [4:0]  t_op  [6] = '{5'd4, 5'd4, 5'd5, 5'd3, 5'd2, 5'd6};
    logic [31:0] t_imm [6] = '{32'd4, 32'd33, 32'd1, 32'd8, 32'd6, 32'd0};
    logic [31:0] t_exp [6] = '{32'h30, 32'h6, 32'h1, 32'hB, 32'h2, 32'hFFFF_FFFC};
    int lat;
    logic [31:0] v;
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], 4'd14, 4'd2, 4'd0, 1'b1, t_imm[i], lat);
      rd(4'd14, v);
      checks++;
      if (v !== t_exp[i]) $display("FAIL alu_vec%0d op=%0d got %h exp %h", i, t_op[i], v, t_exp[i]);
      else passes++;
    end
  endtask

  task automatic test_mul;
    int lat;
    logic [31:0] v;
    preload(4'd5, 32'hFFFF_FFFF);
    preload(4'd6, 32'd2);
    preload(4'd9, 32'h55);
    run_op(5'd8, 4'd9, 4'd5, 4'd6, 1'b0, 32'h0, lat);
    checks++; if (lat !== 4) $display("FAIL mul_latency got %0d exp 4", lat); else passes++;
    checks++; if (hi !== 32'h1) $display("FAIL mul_hi got %h exp 1", hi); else passes++;
    checks++; if (lo !== 32'hFFFF_FFFE) $display("FAIL mul_lo got %h exp fffffffe", lo); else passes++;
    checks++; if (result !== 32'hFFFF_FFFE) $display("FAIL mul_result got %h exp fffffffe", result); else passes++;
    rd(4'd9, v);
    checks++; if (v !== 32'h55) $display("FAIL mul_ra_kept got %h exp 55", v); else passes++;
  endtask

  task automatic test_back_to_back;
    int acc, d0, d1, n;
    logic [31:0] v;
    preload(4'd2, 32'd7);
    d0 = -100; d1 = -100; n = 0;
    @(negedge clock);
    opcode = 5'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3; use_imm = 1'b0; op_valid = 1'b1;
    @(posedge clock);
    #1 acc = cyc;
    ra = 4'd7; rb = 4'd1; rc = 4'd1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (done) begin
        if (n == 0) d0 = cyc; else if (n == 1) d1 = cyc;
        n++;
        if (n == 1) begin
          @(posedge clock);
          #1 op_valid = 1'b0;
        end
      end
    end
    op_valid = 1'b0;
    checks++; if (d0 - acc !== 3) $display("FAIL b2b_first_lat got %0d exp 3", d0 - acc); else passes++;
    checks++; if (d1 - d0 !== 4) $display("FAIL b2b_spacing got %0d exp 4", d1 - d0); else passes++;
    checks++; if (n !== 2) $display("FAIL b2b_done_count got %0d exp 2", n); else passes++;
    rd(4'd7, v);
    checks++; if (v !== 32'd24) $display("FAIL b2b_r7 got %h exp 18", v); else passes++;
  endtask

  task automatic test_illegal;
    int lat;
    logic [31:0] v;
    run_op(5'd15, 4'd1, 4'd2, 4'd3, 1'b0, 32'h0, lat);
    checks++; if (lat !== 3) $display("FAIL illegal_latency got %0d exp 3", lat); else passes++;
    checks++; if (err !== 1'b1) $display("FAIL illegal_err got %b exp 1", err); else passes++;
    checks++; if (result !== 32'd24) $display("FAIL illegal_result got %h exp 18", result); else passes++;
    rd(4'd1, v);
    checks++; if (v !== 32'd12) $display("FAIL illegal_r1 got %h exp c", v); else passes++;
    @(negedge clock);
    checks++; if (err !== 1'b0) $display("FAIL illegal_err_clears got %b exp 0", err); else passes++;
  endtask

  task automatic test_ld_busy;
    logic [31:0] v;
    @(negedge clock);
    opcode = 5'd2; ra = 4'd10; rb = 4'd2; rc = 4'd3; use_imm = 1'b0; op_valid = 1'b1;
    @(posedge clock);
    #1 op_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    ld_en = 1'b1; ld_addr = 4'd11; ld_data = 32'hAA;
    @(posedge clock);
    #1 ld_en = 1'b0;
    for (int i = 0; i < 10 && !done; i++) @(negedge clock);
    checks++; if (done !== 1'b1) $display("FAIL ldbusy_done got %b exp 1", done); else passes++;
    rd(4'd11, v);
    checks++; if (v !== 32'h0) $display("FAIL ldbusy_r11 got %h exp 0", v); else passes++;
    rd(4'd10, v);
    checks++; if (v !== 32'h5) $display("FAIL ldbusy_and_r10 got %h exp 5", v); else passes++;
  endtask

  task automatic test_ld_accept;
    logic [31:0] v;
    @(negedge clock);
    ld_en = 1'b1; ld_addr = 4'd12; ld_data = 32'd100;
    opcode = 5'd0; ra = 4'd13; rb = 4'd12; rc = 4'd0; use_imm = 1'b1; imm = 32'd1; op_valid = 1'b1;
    @(posedge clock);
    #1 op_valid = 1'b0;
    ld_en = 1'b0;
    for (int i = 0; i < 10 && !done; i++) @(negedge clock);
    rd(4'd13, v);
    checks++; if (v !== 32'd101) $display("FAIL ldacc_r13 got %0d exp 101", v); else passes++;
  endtask

  task automatic test_clear_mid;
    int seen;
    logic [31:0] v;
    @(negedge clock);
    opcode = 5'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3; use_imm = 1'b0; op_valid = 1'b1;
    @(posedge clock);
    #1 op_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 clear = 1'b0;
    #10;
    checks++; if (op_ready !== 1'b1) $display("FAIL clr_ready_in_reset got %b exp 1", op_ready); else passes++;
    @(negedge clock);
    clear = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL clr_no_done got %0d exp 0", seen); else passes++;
    checks++; if (op_ready !== 1'b1) $display("FAIL clr_ready got %b exp 1", op_ready); else passes++;
    checks++; if ({hi, lo, result} !== 96'h0) $display("FAIL clr_hilo_result got %h exp 0", {hi, lo, result}); else passes++;
    rd(4'd7, v);
    checks++; if (v !== 32'h0) $display("FAIL clr_r7 got %h exp 0", v); else passes++;
    rd(4'd2, v);
    checks++; if (v !== 32'h0) $display("FAIL clr_r2 got %h exp 0", v); else passes++;
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_neg;
    test_logic_shift;
    test_mul;
    test_back_to_back;
    test_illegal;
    test_ld_busy;
    test_ld_accept;
    test_clear_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
